// File: rtl/pico_mem_axi_bridge_pkg.sv
// Shared types and constants for the PicoRV32 native-memory to AXI4-lite bridge.
package pico_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_D  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4,
        DONE  = 3'd5,
        DRAIN = 3'd6
    } bridge_state_e;

    localparam logic [2:0]  PROT_INSN    = 3'b100;
    localparam logic [2:0]  PROT_DATA    = 3'b000;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/pico_mem_axi_bridge_if.sv
// AXI4-lite channel bundle (32-bit data); response codes are not carried.
interface if_axi_light;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, arready, rvalid, rdata
    );
endinterface

// File: rtl/pico_mem_axi_bridge_timer.sv
// Loadable down-counter: expire is high once TIMEOUT enabled cycles have elapsed since restart.
module pico_axi_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic res_n,
    input  logic restart,
    input  logic en,
    output logic expire
);
    generate
        if (TIMEOUT == 0) begin : g_off
            wire unused_ok = &{1'b0, clk, res_n, restart, en};
            assign expire = 1'b0;
        end else begin : g_on
            localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);

            logic [W-1:0] cnt_q;
            logic [W-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (restart) begin
                    cnt_d = LOAD;
                end else if (en && cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            always_ff @(posedge clk or negedge res_n) begin
                if (!res_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expire = en && (cnt_q == '0);
        end
    endgenerate
endmodule

// File: rtl/pico_mem_axi_bridge.sv
// PicoRV32 native memory port to AXI4-lite master, with address window, relocation,
// per-phase timeout with AXI-safe drain, sticky error flags and saturating traffic counters.
module pico_mem_axi_bridge
    import pico_bridge_pkg::*;
#(
    parameter logic [31:0] WIN_SIZE  = 32'h0001_0000,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          TIMEOUT   = 1024,
    parameter logic [31:0] ERR_DATA  = ERR_DATA_DEF,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             mem_valid,
    input  logic             mem_instr,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    if_axi_light.master      m_axi,
    output logic             err_win,
    output logic             err_tmo,
    input  logic             err_clr,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);
    bridge_state_e state_q, state_d;

    logic             mem_ready_q, mem_ready_d;
    logic [31:0]      mem_rdata_q, mem_rdata_d;
    logic             is_wr_q, is_wr_d;
    logic             arvalid_q, arvalid_d;
    logic [31:0]      araddr_q, araddr_d;
    logic [2:0]       arprot_q, arprot_d;
    logic             rready_q, rready_d;
    logic             awvalid_q, awvalid_d;
    logic [31:0]      awaddr_q, awaddr_d;
    logic             wvalid_q, wvalid_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             bready_q, bready_d;
    logic             err_win_q, err_win_d;
    logic             err_tmo_q, err_tmo_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

    logic tmr_restart, tmr_en, tmr_expire;
    logic win_set, tmo_set, rd_inc, wr_inc;
    logic aw_hs, w_hs;

    assign tmr_en = (state_q == RD_A) || (state_q == RD_D) ||
                    (state_q == WR_AW) || (state_q == WR_B);

    pico_axi_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .res_n   (res_n),
        .restart (tmr_restart),
        .en      (tmr_en),
        .expire  (tmr_expire)
    );

    assign aw_hs = awvalid_q && m_axi.awready;
    assign w_hs  = wvalid_q && m_axi.wready;

    always_comb begin
        state_d     = state_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        is_wr_d     = is_wr_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        arprot_d    = arprot_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        awaddr_d    = awaddr_q;
        wvalid_d    = wvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bready_d    = bready_q;
        tmr_restart = 1'b0;
        win_set     = 1'b0;
        tmo_set     = 1'b0;
        rd_inc      = 1'b0;
        wr_inc      = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_valid && !mem_ready_q) begin
                    if (mem_addr >= WIN_SIZE) begin
                        mem_rdata_d = ERR_DATA;
                        win_set     = 1'b1;
                        state_d     = DONE;
                    end else if (mem_wstrb == 4'b0000) begin
                        araddr_d    = mem_addr + ADDR_BASE;
                        arprot_d    = mem_instr ? PROT_INSN : PROT_DATA;
                        arvalid_d   = 1'b1;
                        is_wr_d     = 1'b0;
                        tmr_restart = 1'b1;
                        state_d     = RD_A;
                    end else begin
                        awaddr_d    = mem_addr + ADDR_BASE;
                        wdata_d     = mem_wdata;
                        wstrb_d     = mem_wstrb;
                        awvalid_d   = 1'b1;
                        wvalid_d    = 1'b1;
                        is_wr_d     = 1'b1;
                        tmr_restart = 1'b1;
                        state_d     = WR_AW;
                    end
                end
            end
            RD_A: begin
                if (m_axi.arready) begin
                    arvalid_d   = 1'b0;
                    rready_d    = 1'b1;
                    tmr_restart = 1'b1;
                    state_d     = RD_D;
                end else if (tmr_expire) begin
                    tmo_set = 1'b1;
                end
            end
            RD_D: begin
                if (m_axi.rvalid) begin
                    mem_rdata_d = m_axi.rdata;
                    rready_d    = 1'b0;
                    mem_ready_d = 1'b1;
                    rd_inc      = 1'b1;
                    state_d     = DONE;
                end else if (tmr_expire) begin
                    tmo_set = 1'b1;
                end
            end
            WR_AW: begin
                awvalid_d = awvalid_q && !m_axi.awready;
                wvalid_d  = wvalid_q && !m_axi.wready;
                if (aw_hs || w_hs) begin
                    tmr_restart = 1'b1;
                end
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end else if (tmr_expire && !aw_hs && !w_hs) begin
                    tmo_set = 1'b1;
                end
            end
            WR_B: begin
                if (m_axi.bvalid) begin
                    bready_d    = 1'b0;
                    mem_ready_d = 1'b1;
                    wr_inc      = 1'b1;
                    state_d     = DONE;
                end else if (tmr_expire) begin
                    tmo_set = 1'b1;
                end
            end
            DONE: begin
                // AXI paths enter with mem_ready already set; a window miss pulses here.
                if (mem_ready_q) begin
                    state_d = IDLE;
                end else begin
                    mem_ready_d = 1'b1;
                end
            end
            DRAIN: begin
                if (is_wr_q) begin
                    awvalid_d = awvalid_q && !m_axi.awready;
                    wvalid_d  = wvalid_q && !m_axi.wready;
                    if (bready_q && m_axi.bvalid) begin
                        bready_d = 1'b0;
                        state_d  = IDLE;
                    end else if (!awvalid_d && !wvalid_d) begin
                        bready_d = 1'b1;
                    end
                end else begin
                    if (arvalid_q && m_axi.arready) begin
                        arvalid_d = 1'b0;
                        rready_d  = 1'b1;
                    end
                    if (rready_q && m_axi.rvalid) begin
                        rready_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abandon the CPU side now; raised valids are retired in DRAIN.
        if (tmo_set) begin
            mem_ready_d = 1'b1;
            mem_rdata_d = ERR_DATA;
            state_d     = DRAIN;
        end
    end

    always_comb begin
        err_win_d = win_set || (err_win_q && !err_clr);
        err_tmo_d = tmo_set || (err_tmo_q && !err_clr);
        rd_cnt_d  = (rd_inc && rd_cnt_q != '1) ? rd_cnt_q + 1'b1 : rd_cnt_q;
        wr_cnt_d  = (wr_inc && wr_cnt_q != '1) ? wr_cnt_q + 1'b1 : wr_cnt_q;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q     <= IDLE;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            is_wr_q     <= 1'b0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arprot_q    <= '0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            wvalid_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bready_q    <= 1'b0;
            err_win_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            is_wr_q     <= is_wr_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            arprot_q    <= arprot_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            wvalid_q    <= wvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bready_q    <= bready_d;
            err_win_q   <= err_win_d;
            err_tmo_q   <= err_tmo_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    assign mem_ready     = mem_ready_q;
    assign mem_rdata     = mem_rdata_q;
    assign err_win       = err_win_q;
    assign err_tmo       = err_tmo_q;
    assign rd_cnt        = rd_cnt_q;
    assign wr_cnt        = wr_cnt_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arprot  = arprot_q;
    assign m_axi.rready  = rready_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awprot  = PROT_DATA;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.bready  = bready_q;
endmodule

// File: tb/tb_pico_mem_axi_bridge.sv
// Directed bench: CPU-side requests push expected responses into queues that
// negedge monitors pop and compare against the mem and AXI outputs.
module tb_pico_mem_axi_bridge;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    localparam logic [31:0] BASE = 32'h2000_0000;

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        err_win, err_tmo;
    logic        err_clr = 1'b0;
    logic [3:0]  rd_cnt, wr_cnt;

    if_axi_light axi ();

    pico_mem_axi_bridge #(
        .WIN_SIZE (32'h0001_0000),
        .ADDR_BASE(BASE),
        .TIMEOUT  (8),
        .ERR_DATA (ERR),
        .CNT_W    (4)
    ) dut (
        .clk      (clk),
        .res_n    (res_n),
        .mem_valid(mem_valid),
        .mem_instr(mem_instr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .m_axi    (axi),
        .err_win  (err_win),
        .err_tmo  (err_tmo),
        .err_clr  (err_clr),
        .rd_cnt   (rd_cnt),
        .wr_cnt   (wr_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // ---------------- AXI slave model ----------------
    int          ar_wait = 0, aw_wait = 0, w_wait = 0;
    bit          ar_block = 1'b0, b_block = 1'b0;
    logic [31:0] slave_rdata = '0;
    logic [7:0]  ar_age, aw_age, w_age;
    logic        r_pend, b_pend, aw_done, w_done;
    int          arvalid_cycles = 0, b_hs_cnt = 0, w_only_cycles = 0;

    assign axi.arready = axi.arvalid && !ar_block && (int'(ar_age) >= ar_wait);
    assign axi.awready = axi.awvalid && (int'(aw_age) >= aw_wait);
    assign axi.wready  = axi.wvalid && (int'(w_age) >= w_wait);
    assign axi.rvalid  = r_pend;
    assign axi.rdata   = slave_rdata;
    assign axi.bvalid  = b_pend && !b_block;

    wire s_aw_hs = axi.awvalid && axi.awready;
    wire s_w_hs  = axi.wvalid && axi.wready;

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ar_age <= '0; aw_age <= '0; w_age <= '0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_done <= 1'b0; w_done <= 1'b0;
        end else begin
            ar_age <= (axi.arvalid && !axi.arready) ? ar_age + 1'b1 : 8'd0;
            aw_age <= (axi.awvalid && !axi.awready) ? aw_age + 1'b1 : 8'd0;
            w_age  <= (axi.wvalid && !axi.wready) ? w_age + 1'b1 : 8'd0;
            if (axi.arvalid && axi.arready) r_pend <= 1'b1;
            else if (axi.rvalid && axi.rready) r_pend <= 1'b0;
            if (axi.bvalid && axi.bready) begin
                b_pend <= 1'b0;
            end else if ((aw_done || s_aw_hs) && (w_done || s_w_hs)) begin
                b_pend <= 1'b1; aw_done <= 1'b0; w_done <= 1'b0;
            end else begin
                if (s_aw_hs) aw_done <= 1'b1;
                if (s_w_hs) w_done <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (axi.arvalid) arvalid_cycles <= arvalid_cycles + 1;
        if (axi.bvalid && axi.bready) b_hs_cnt <= b_hs_cnt + 1;
        if (axi.wvalid && !axi.awvalid) w_only_cycles <= w_only_cycles + 1;
    end

    // ---------------- scoreboard ----------------
    rd_exp_t     exp_rd[$];
    logic [34:0] exp_ar[$];
    logic [31:0] exp_aw[$];
    logic [35:0] exp_w[$];
    rd_exp_t     rd_item;
    logic [34:0] ar_item;
    logic [35:0] w_item;

    always @(negedge clk) begin
        if (res_n) begin
            if (mem_ready) begin
                if (exp_rd.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_mem_ready: got 1 expected 0");
                end else begin
                    rd_item = exp_rd.pop_front();
                    if (rd_item.chk) check("mem_rdata", mem_rdata, rd_item.data);
                end
            end
            if (axi.arvalid && axi.arready) begin
                if (exp_ar.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_ar: araddr 0x%08h", axi.araddr);
                end else begin
                    ar_item = exp_ar.pop_front();
                    check("araddr", axi.araddr, ar_item[34:3]);
                    check("arprot", 32'(axi.arprot), 32'(ar_item[2:0]));
                end
            end
            if (axi.awvalid && axi.awready) begin
                if (exp_aw.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_aw: awaddr 0x%08h", axi.awaddr);
                end else begin
                    check("awaddr", axi.awaddr, exp_aw.pop_front());
                    check("awprot", 32'(axi.awprot), 32'd0);
                end
            end
            if (axi.wvalid && axi.wready) begin
                if (exp_w.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_w: wdata 0x%08h", axi.wdata);
                end else begin
                    w_item = exp_w.pop_front();
                    check("wdata", axi.wdata, w_item[35:4]);
                    check("wstrb", 32'(axi.wstrb), 32'(w_item[3:0]));
                end
            end
        end
    end

    // ---------------- CPU driver ----------------
    task automatic do_req(input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, input logic instr, output int lat);
        bit got = 1'b0;
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wd;
        mem_wstrb = strb; mem_instr = instr;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_ready) begin got = 1'b1; break; end
            lat++;
        end
        if (!got) begin
            n_vec++; n_miss++;
            $display("FAIL mem_ready_wait: no mem_ready within 100 cycles for addr 0x%08h", addr);
        end
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_wstrb = '0; mem_instr = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, n0, exp_cnt;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_ready", 32'(mem_ready), 32'd0);
        check("reset_valids", 32'({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}), 32'd0);
        check("reset_flags_cnts", 32'({err_win, err_tmo, rd_cnt, wr_cnt}), 32'd0);
        res_n = 1'b1;

        // read, minimum latency: valid t0, arvalid t1, rvalid t2, mem_ready t3
        slave_rdata = 32'h1234_5678;
        exp_ar.push_back({BASE + 32'h100, 3'b000});
        exp_rd.push_back('{1'b1, 32'h1234_5678});
        do_req(32'h100, 32'h0, 4'h0, 1'b0, lat);
        check("read_latency", 32'(lat), 32'd3);
        check("rd_cnt_after_read", 32'(rd_cnt), 32'd1);

        // instruction fetch
        slave_rdata = 32'h0000_0013;
        exp_ar.push_back({BASE + 32'h104, 3'b100});
        exp_rd.push_back('{1'b1, 32'h0000_0013});
        do_req(32'h104, 32'h0, 4'h0, 1'b1, lat);
        check("fetch_latency", 32'(lat), 32'd3);
        check("rd_cnt_after_fetch", 32'(rd_cnt), 32'd2);

        // write with awready two cycles ahead of wready: aw@t1, w@t3, b@t4, ready@t5
        aw_wait = 0; w_wait = 2;
        n0 = b_hs_cnt;
        exp_cnt = w_only_cycles;
        exp_aw.push_back(BASE + 32'h300);
        exp_w.push_back({32'hCAFE_F00D, 4'b0011});
        exp_rd.push_back('{1'b0, 32'h0});
        do_req(32'h300, 32'hCAFE_F00D, 4'b0011, 1'b0, lat);
        check("write_latency", 32'(lat), 32'd5);
        check("write_b_handshakes", 32'(b_hs_cnt - n0), 32'd1);
        check("write_w_only_cycles", 32'(w_only_cycles - exp_cnt), 32'd2);
        check("wr_cnt_after_write", 32'(wr_cnt), 32'd1);
        w_wait = 0;

        // window miss
        n0 = arvalid_cycles;
        exp_rd.push_back('{1'b1, ERR});
        do_req(32'h0001_0000, 32'h0, 4'h0, 1'b0, lat);
        check("miss_latency", 32'(lat), 32'd2);
        check("miss_no_arvalid", 32'(arvalid_cycles - n0), 32'd0);
        check("err_win_set", 32'(err_win), 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("err_win_cleared", 32'(err_win), 32'd0);

        // timeout with arready held low: arvalid t1..t8 (8 cycles), mem_ready t9
        ar_block = 1'b1;
        slave_rdata = 32'h5555_5555;
        exp_ar.push_back({BASE + 32'h200, 3'b000});
        exp_rd.push_back('{1'b1, ERR});
        do_req(32'h200, 32'h0, 4'h0, 1'b0, lat);
        check("timeout_latency", 32'(lat), 32'd9);
        check("err_tmo_set", 32'(err_tmo), 32'd1);
        check("arvalid_held_after_tmo", 32'(axi.arvalid), 32'd1);
        check("rd_cnt_after_tmo", 32'(rd_cnt), 32'd2);
        repeat (10) @(posedge clk);
        #1;
        ar_block = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axi.rvalid && axi.rready) begin seen = 1'b1; break; end
        end
        check("drain_r_accepted", 32'(seen), 32'd1);
        slave_rdata = 32'h1111_2222;
        exp_ar.push_back({BASE + 32'h204, 3'b000});
        exp_rd.push_back('{1'b1, 32'h1111_2222});
        do_req(32'h204, 32'h0, 4'h0, 1'b0, lat);
        check("rd_cnt_after_recover", 32'(rd_cnt), 32'd3);

        // asynchronous reset while waiting in WR_B
        b_block = 1'b1;
        exp_aw.push_back(BASE + 32'h400);
        exp_w.push_back({32'h0BAD_F00D, 4'hF});
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = 32'h400; mem_wdata = 32'h0BAD_F00D; mem_wstrb = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axi.bready) begin seen = 1'b1; break; end
        end
        check("reached_wr_b", 32'(seen), 32'd1);
        #2;
        res_n = 1'b0;
        mem_valid = 1'b0; mem_wstrb = '0;
        #1;
        check("async_reset_valids", 32'({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}), 32'd0);
        check("async_reset_mem_ready", 32'(mem_ready), 32'd0);
        check("async_reset_flags_cnts", 32'({err_win, err_tmo, rd_cnt, wr_cnt}), 32'd0);
        b_block = 1'b0;
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        slave_rdata = 32'h7777_0000;
        exp_ar.push_back({BASE + 32'h10, 3'b000});
        exp_rd.push_back('{1'b1, 32'h7777_0000});
        do_req(32'h10, 32'h0, 4'h0, 1'b0, lat);
        check("post_reset_latency", 32'(lat), 32'd3);

        // saturation of the 4-bit read counter
        exp_cnt = 1;
        for (int i = 0; i < 20; i++) begin
            slave_rdata = 32'h100 + 32'(i);
            exp_ar.push_back({BASE + 32'(4 * i), 3'b000});
            exp_rd.push_back('{1'b1, 32'h100 + 32'(i)});
            do_req(32'(4 * i), 32'h0, 4'h0, 1'b0, lat);
            exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
            check("rd_cnt_sat", 32'(rd_cnt), 32'(exp_cnt));
        end

        repeat (5) @(posedge clk);
        #1;
        check("leftover_exp_rd", 32'(exp_rd.size()), 32'd0);
        check("leftover_exp_ar", 32'(exp_ar.size()), 32'd0);
        check("leftover_exp_aw_w", 32'(exp_aw.size() + exp_w.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
